mips_multicycle_ctrl: RTL

- Main control FSM that sequences a multicycle MIPS datapath with one shared instruction/data memory and one ALU.
- Drives every mux select and write enable in the datapath from the latched opcode/funct and the ALU zero flag.
- Counts fetched instructions for bench and debug visibility.
- Drop-in replacement for the single-cycle control decoder when the core moves to multicycle.

---
 rtl/mips_multicycle_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS datapath.
// Sequences shared memory/ALU and counts fetched instructions.
module mips_multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 pcen,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [2:0]           alucontrol,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [INSTRET_W-1:0] ONE =
    {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_t     st, nxt;
  logic       r_ok;
  logic [2:0] alu_f;
  logic       pcen_c, memwrite_c, irwrite_c, regwrite_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= FETCH;
      instret <= '0;
    end else begin
      st <= nxt;
      if (st == FETCH) instret <= instret + ONE;
    end
  end

  always_comb begin
    r_ok  = 1'b1;
    alu_f = 3'b010;
    case (funct)
      6'b100000: alu_f = 3'b010;
      6'b100010: alu_f = 3'b110;
      6'b100100: alu_f = 3'b000;
      6'b100101: alu_f = 3'b001;
      6'b101010: alu_f = 3'b111;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt        = FETCH;
    pcen_c     = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    illegal    = 1'b0;
    case (st)
      FETCH: begin
        nxt       = DECODE;
        alusrcb   = 2'b01;
        irwrite_c = 1'b1;
        pcen_c    = 1'b1;
      end
      DECODE: begin
        // ALU precomputes the branch target while op is decoded
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:   nxt = MEMADR;
          OP_R: begin
            if (r_ok) nxt = EXECUTE;
            else illegal = 1'b1;
          end
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:        nxt = ADDIEX;
          OP_J:           nxt = JUMP;
          default:        illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        nxt     = (op == OP_SW) ? MEMWR : MEMRD;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        nxt  = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      EXECUTE: begin
        nxt        = ALUWB;
        alusrca    = 1'b1;
        alucontrol = alu_f;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen_c     = (op == OP_BNE) ? ~zero : zero;
      end
      ADDIEX: begin
        nxt     = ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite_c = 1'b1;
      JUMP: begin
        pcsrc  = 2'b10;
        pcen_c = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Strobes are gated so a mid-instruction reset kills the write at once
  assign pcen     = pcen_c & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign irwrite  = irwrite_c & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign state    = st;

endmodule
